// File: rtl/ifu_inst_queue_if.sv
// Handshake bundle between the IFU, the instruction queue and the IDU.
// The queue takes the slave side; the fetch/decode side (or a bench) takes the master side.
interface ifu_inst_queue_if;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [1:0]  out_ctrl;

  modport master (
    output flush, in_valid, in_pc, in_inst, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, out_ctrl
  );

  modport slave (
    input  flush, in_valid, in_pc, in_inst, out_ready,
    output in_ready, out_valid, out_pc, out_inst, out_ctrl
  );
endinterface

// File: rtl/ifu_inst_queue.sv
// Decoupling queue of predecoded {pc, inst} pairs between IFU and IDU.
// A redirect flush empties the queue in one cycle; there is no write-to-read bypass.
module ifu_inst_queue #(
  parameter int DEPTH = 4
) (
  input logic             clock,
  input logic             reset,
  ifu_inst_queue_if.slave q
);
  localparam int          PW   = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

  logic [31:0]   pc_q   [DEPTH];
  logic [31:0]   pc_d   [DEPTH];
  logic [31:0]   inst_q [DEPTH];
  logic [31:0]   inst_d [DEPTH];
  logic [1:0]    ctrl_q [DEPTH];
  logic [1:0]    ctrl_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          push, pop;

  // Class is taken from inst[6:2] only, so compressed-looking low bits are ignored.
  function automatic logic [1:0] predecode(input logic [31:0] inst);
    logic [1:0] cls;
    case (inst[6:2])
      5'b11000:          cls = 2'd1;
      5'b11011, 5'b11001: cls = 2'd2;
      5'b11100, 5'b00011: cls = 2'd3;
      default:           cls = 2'd0;
    endcase
    return cls;
  endfunction

  // in_ready depends on registered occupancy only, keeping out_ready off that path.
  assign q.in_ready  = (cnt_q != FULL);
  assign q.out_valid = (cnt_q != '0) & ~q.flush;
  assign push        = q.in_valid & q.in_ready & ~q.flush;
  assign pop         = q.out_valid & q.out_ready;

  assign q.out_pc   = pc_q[rd_ptr_q];
  assign q.out_inst = inst_q[rd_ptr_q];
  assign q.out_ctrl = ctrl_q[rd_ptr_q];

  always_comb begin
    pc_d     = pc_q;
    inst_d   = inst_q;
    ctrl_d   = ctrl_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (q.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        pc_d[wr_ptr_q]   = q.in_pc;
        inst_d[wr_ptr_q] = q.in_inst;
        ctrl_d[wr_ptr_q] = predecode(q.in_inst);
        wr_ptr_d         = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      cnt_d = cnt_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
        ctrl_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      ctrl_q   <= ctrl_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: tb/tb_ifu_inst_queue.sv
// Self-checking bench for ifu_inst_queue: directed vector table, hand-written
// corner sequences and random traffic checked against a queue-based model.
module tb_ifu_inst_queue;
  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ifu_inst_queue_if bus ();

  ifu_inst_queue #(.DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .q     (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;
  ent_t mq[$];

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        rdy;
    logic        exp_valid;
    logic        exp_ready;
    logic [31:0] exp_pc;
    logic [1:0]  exp_ctrl;
  } vec_t;
  vec_t tbl[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction class straight from the opcode classes the IDU expects.
  function automatic logic [1:0] ref_class(input logic [31:0] inst);
    logic [4:0] op;
    op = inst[6:2];
    if (op == 5'b11000) return 2'd1;
    if (op == 5'b11011 || op == 5'b11001) return 2'd2;
    if (op == 5'b11100 || op == 5'b00011) return 2'd3;
    return 2'd0;
  endfunction

  function automatic vec_t mk(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                              input logic rdy, input logic ev, input logic er,
                              input logic [31:0] epc, input logic [1:0] ectrl);
    vec_t r;
    r.v = v; r.pc = pc; r.inst = inst; r.rdy = rdy;
    r.exp_valid = ev; r.exp_ready = er; r.exp_pc = epc; r.exp_ctrl = ectrl;
    return r;
  endfunction

  task automatic model_step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                            input logic rdy, input logic fl);
    bit do_pop, do_push;
    ent_t e;
    if (fl) begin
      mq.delete();
    end else begin
      do_pop  = (mq.size() > 0) && rdy;
      do_push = v && (mq.size() < DEPTH);
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        e.pc = pc; e.inst = inst;
        mq.push_back(e);
      end
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic rdy, input logic fl);
    bus.in_valid  = v;
    bus.in_pc     = pc;
    bus.in_inst   = inst;
    bus.out_ready = rdy;
    bus.flush     = fl;
  endtask

  // One cycle: drive, compare against the model at the falling edge, clock, advance model.
  task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                     input logic rdy, input logic fl);
    drive(v, pc, inst, rdy, fl);
    @(negedge clock);
    chk("in_ready", 32'(bus.in_ready), 32'(mq.size() != DEPTH));
    chk("out_valid", 32'(bus.out_valid), 32'((mq.size() != 0) && !fl));
    if (mq.size() != 0 && !fl) begin
      chk("out_pc", bus.out_pc, mq[0].pc);
      chk("out_inst", bus.out_inst, mq[0].inst);
      chk("out_ctrl", 32'(bus.out_ctrl), 32'(ref_class(mq[0].inst)));
    end
    @(posedge clock);
    model_step(v, pc, inst, rdy, fl);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clock);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_out_pc"}, bus.out_pc, 32'd0);
    chk({tag, "_out_inst"}, bus.out_inst, 32'd0);
    chk({tag, "_out_ctrl"}, 32'(bus.out_ctrl), 32'd0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    mq.delete();
    check_reset_state("por");

    // Fill to full, refuse a 5th, drain in order, then predecode classes.
    tbl[0]  = mk(1, 32'h80000000, 32'h13, 0, 0, 1, 32'h0, 2'd0);
    tbl[1]  = mk(1, 32'h80000004, 32'h13, 0, 1, 1, 32'h80000000, 2'd0);
    tbl[2]  = mk(1, 32'h80000008, 32'h13, 0, 1, 1, 32'h80000000, 2'd0);
    tbl[3]  = mk(1, 32'h8000000C, 32'h13, 0, 1, 1, 32'h80000000, 2'd0);
    tbl[4]  = mk(1, 32'h80000010, 32'h13, 0, 1, 0, 32'h80000000, 2'd0);
    tbl[5]  = mk(0, 32'h0, 32'h0, 1, 1, 0, 32'h80000000, 2'd0);
    tbl[6]  = mk(0, 32'h0, 32'h0, 1, 1, 1, 32'h80000004, 2'd0);
    tbl[7]  = mk(0, 32'h0, 32'h0, 1, 1, 1, 32'h80000008, 2'd0);
    tbl[8]  = mk(0, 32'h0, 32'h0, 1, 1, 1, 32'h8000000C, 2'd0);
    tbl[9]  = mk(0, 32'h0, 32'h0, 1, 0, 1, 32'h0, 2'd0);
    tbl[10] = mk(1, 32'h100, 32'h00000063, 1, 0, 1, 32'h0, 2'd0);
    tbl[11] = mk(1, 32'h104, 32'h0000006F, 1, 1, 1, 32'h100, 2'd1);
    tbl[12] = mk(1, 32'h108, 32'h00000067, 1, 1, 1, 32'h104, 2'd2);
    tbl[13] = mk(1, 32'h10C, 32'h00100073, 1, 1, 1, 32'h108, 2'd2);
    tbl[14] = mk(1, 32'h110, 32'h00000013, 1, 1, 1, 32'h10C, 2'd3);
    tbl[15] = mk(0, 32'h0, 32'h0, 1, 1, 1, 32'h110, 2'd0);
    tbl[16] = mk(0, 32'h0, 32'h0, 1, 0, 1, 32'h0, 2'd0);

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].v, tbl[i].pc, tbl[i].inst, tbl[i].rdy, 1'b0);
      @(negedge clock);
      chk($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'(tbl[i].exp_ready));
      chk($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) begin
        chk($sformatf("vec%0d_out_pc", i), bus.out_pc, tbl[i].exp_pc);
        chk($sformatf("vec%0d_out_ctrl", i), 32'(bus.out_ctrl), 32'(tbl[i].exp_ctrl));
      end
      @(posedge clock);
      model_step(tbl[i].v, tbl[i].pc, tbl[i].inst, tbl[i].rdy, 1'b0);
      #1;
    end
    $display("table vectors applied: total=%0d", total);

    // Flush with cnt=3 and a pc presented alongside it.
    for (int k = 0; k < 3; k++) cyc(1, 32'h200 + 32'(4 * k), 32'h13, 0, 0);
    drive(1, 32'hDEAD0000, 32'h13, 0, 1);
    @(negedge clock);
    chk("flush_same_cycle_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clock);
    model_step(1, 32'hDEAD0000, 32'h13, 0, 1);
    #1;
    drive(0, 32'h0, 32'h0, 1, 0);
    @(negedge clock);
    chk("after_flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("after_flush_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clock);
    model_step(0, 32'h0, 32'h0, 1, 0);
    #1;
    cyc(1, 32'h300, 32'h6F, 0, 0);
    cyc(0, 32'h0, 32'h0, 1, 0);
    $display("flush sequence done: total=%0d", total);

    // Sustained streaming across several pointer wraps.
    cyc(1, 32'h1000, 32'h13, 1, 0);
    for (int k = 1; k <= 20; k++) begin
      cyc(1, 32'h1000 + 32'(4 * k), 32'h13, 1, 0);
      chk("stream_occupancy", 32'(mq.size()), 32'd1);
    end
    cyc(0, 32'h0, 32'h0, 1, 0);
    $display("streaming done: total=%0d", total);

    // Reset in the middle of traffic with two entries queued.
    cyc(1, 32'h400, 32'h63, 0, 0);
    cyc(1, 32'h404, 32'h73, 0, 0);
    drive(1, 32'h408, 32'h13, 1, 0);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    mq.delete();
    drive(0, 32'h0, 32'h0, 0, 0);
    check_reset_state("midrst");

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      logic [31:0] inst;
      logic [4:0]  ops[6];
      ops[0] = 5'b11000; ops[1] = 5'b11011; ops[2] = 5'b11001;
      ops[3] = 5'b11100; ops[4] = 5'b00011; ops[5] = 5'b00100;
      inst = $urandom;
      if ($urandom_range(0, 3) != 0) inst[6:2] = ops[$urandom_range(0, 5)];
      cyc(1'($urandom_range(0, 3) != 0), $urandom & 32'hFFFF_FFFC, inst,
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
